// File: rtl/fw_wishbone_initiator_cmd.sv
// Wishbone classic initiator: turns a valid/ready command stream into single bus
// cycles and returns one response per command, with an optional bus-hang timeout.
module fw_wishbone_initiator_cmd #(
  parameter int unsigned ADR_WIDTH      = 32,
  parameter int unsigned DAT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // command stream
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADR_WIDTH-1:0]   cmd_adr,
  input  logic [DAT_WIDTH-1:0]   cmd_dat,
  input  logic                   cmd_we,
  input  logic [DAT_WIDTH/8-1:0] cmd_sel,
  // response stream
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DAT_WIDTH-1:0]   rsp_dat,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  // wishbone initiator
  output logic [ADR_WIDTH-1:0]   i_adr,
  output logic [DAT_WIDTH-1:0]   i_dat_w,
  input  logic [DAT_WIDTH-1:0]   i_dat_r,
  output logic                   i_cyc,
  output logic                   i_stb,
  output logic                   i_we,
  output logic [DAT_WIDTH/8-1:0] i_sel,
  input  logic                   i_ack,
  input  logic                   i_err
);

  localparam int unsigned SEL_WIDTH  = DAT_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] to_cnt;
  logic                 timeout_hit;

  // Abort on the last allowed bus cycle so i_cyc stays high exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = TIMEOUT_EN && (to_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      i_adr       <= '0;
      i_dat_w     <= '0;
      i_cyc       <= 1'b0;
      i_stb       <= 1'b0;
      i_we        <= 1'b0;
      i_sel       <= SEL_WIDTH'(0);
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_BUS;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            i_adr     <= cmd_adr;
            i_dat_w   <= cmd_dat;
            i_we      <= cmd_we;
            i_sel     <= cmd_sel;
            i_cyc     <= 1'b1;
            i_stb     <= 1'b1;
          end
        end

        // Completion priority: error, then acknowledge, then timeout.
        ST_BUS: begin
          if (i_err || i_ack || timeout_hit) begin
            state     <= ST_RSP;
            i_cyc     <= 1'b0;
            i_stb     <= 1'b0;
            rsp_valid <= 1'b1;
            if (i_err) begin
              rsp_err <= 1'b1;
              rsp_dat <= '0;
            end else if (i_ack) begin
              rsp_dat <= i_we ? '0 : i_dat_r;
            end else begin
              rsp_timeout <= 1'b1;
              rsp_dat     <= '0;
            end
          end else begin
            to_cnt <= to_cnt + CNT_WIDTH'(1);
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          i_cyc     <= 1'b0;
          i_stb     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fw_wishbone_initiator_cmd.sv
// Directed bench for fw_wishbone_initiator_cmd against a small behavioural SRAM target
// with programmable wait states and ack/err/silent behaviour.
module tb_fw_wishbone_initiator_cmd;

  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] i_adr;
  logic [31:0] i_dat_w;
  logic [31:0] i_dat_r;
  logic        i_cyc;
  logic        i_stb;
  logic        i_we;
  logic [3:0]  i_sel;
  logic        i_ack;
  logic        i_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fw_wishbone_initiator_cmd #(
    .ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_cyc(i_cyc),
    .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_ack(i_ack), .i_err(i_err)
  );

  // Target model: mode 0 ack, 1 silent, 2 err, 3 ack+err; responds tgt_wait cycles late.
  logic [31:0] mem [16];
  int          tgt_wait = 0;
  int          tgt_mode = 0;
  int          wcnt;
  logic        tgt_ack, tgt_err;
  logic [31:0] tgt_dat;
  logic        f_ack = 1'b0;
  logic        f_err = 1'b0;

  assign i_ack   = tgt_ack | f_ack;
  assign i_err   = tgt_err | f_err;
  assign i_dat_r = tgt_dat;

  always @(posedge clock) begin
    tgt_ack <= 1'b0;
    tgt_err <= 1'b0;
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) mem[k] <= (k == 0) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(k));
      wcnt    <= 0;
      tgt_dat <= '0;
    end else if (i_cyc && i_stb && !tgt_ack && !tgt_err) begin
      if (wcnt == tgt_wait) begin
        wcnt <= 0;
        case (tgt_mode)
          0: begin
            tgt_ack <= 1'b1;
            if (i_we) begin
              for (int b = 0; b < 4; b++)
                if (i_sel[b]) mem[i_adr[5:2]][8*b +: 8] <= i_dat_w[8*b +: 8];
            end else begin
              tgt_dat <= mem[i_adr[5:2]];
            end
          end
          2: tgt_err <= 1'b1;
          3: begin
            tgt_ack <= 1'b1;
            tgt_err <= 1'b1;
            tgt_dat <= mem[i_adr[5:2]];
          end
          default: ;
        endcase
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!i_cyc) begin
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One full command with rsp_ready held high; counts i_cyc cycles and checks bus stability.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output logic rerr,
                        output logic rto, output int ncyc, output logic stable, output logic done);
    logic ok;
    rdat = '0; rerr = 1'b0; rto = 1'b0; ncyc = 0; stable = 1'b1; done = 1'b0;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    step();
    cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (i_cyc) begin
        ncyc++;
        if (i_adr !== adr || i_we !== we || i_sel !== sel || i_stb !== 1'b1 ||
            (we && i_dat_w !== dat)) stable = 1'b0;
      end
      if (rsp_valid) begin
        rdat = rsp_dat; rerr = rsp_err; rto = rsp_timeout; done = 1'b1;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_n;
    int          mode;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd;
    logic        re, rt, st, dn, ok, flag;
    int          nc;

    vecs[0]  = '{1'b0, 32'h100, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b1, 32'h104, 32'h12345678, 4'h3, 0, 0, 32'h0,        1'b0, 1'b0, 2};
    vecs[2]  = '{1'b0, 32'h104, 32'h0,        4'hF, 0, 0, 32'hA5A55678, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b1, 32'h108, 32'hCAFEF00D, 4'hC, 3, 0, 32'h0,        1'b0, 1'b0, 5};
    vecs[4]  = '{1'b0, 32'h108, 32'h0,        4'hF, 1, 0, 32'hCAFE0002, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, 32'h10C, 32'h0,        4'h1, 6, 0, 32'hA5A50003, 1'b0, 1'b0, 8};
    vecs[6]  = '{1'b0, 32'h110, 32'h0,        4'hF, 0, 1, 32'h0,        1'b0, 1'b1, 8};
    vecs[7]  = '{1'b1, 32'h114, 32'h11111111, 4'hF, 1, 2, 32'h0,        1'b1, 1'b0, 3};
    vecs[8]  = '{1'b0, 32'h114, 32'h0,        4'hF, 0, 0, 32'hA5A50005, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b0, 32'h100, 32'h0,        4'hF, 0, 3, 32'h0,        1'b1, 1'b0, 2};
    vecs[10] = '{1'b0, 32'h118, 32'h0,        4'hF, 0, 2, 32'h0,        1'b1, 1'b0, 2};

    repeat (3) @(posedge clock);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_i_cyc", 32'(i_cyc), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_i_adr", i_adr, 32'h0);
    check("reset_rsp_dat", rsp_dat, 32'h0);
    reset_n = 1'b1;
    step();

    for (int v = 0; v < 11; v++) begin
      tgt_wait = vecs[v].wait_n;
      tgt_mode = vecs[v].mode;
      do_cmd(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, rd, re, rt, nc, st, dn);
      check($sformatf("v%0d_done", v), 32'(dn), 32'd1);
      check($sformatf("v%0d_dat", v), rd, vecs[v].exp_dat);
      check($sformatf("v%0d_err", v), 32'(re), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_timeout", v), 32'(rt), 32'(vecs[v].exp_to));
      check($sformatf("v%0d_cyc_cycles", v), 32'(nc), 32'(vecs[v].exp_cyc));
      check($sformatf("v%0d_bus_stable", v), 32'(st), 32'd1);
    end

    // Late ack after a timeout must be ignored.
    tgt_mode = 1;
    do_cmd(1'b0, 32'h100, 32'h0, 4'hF, rd, re, rt, nc, st, dn);
    check("late_ack_timeout", 32'(rt), 32'd1);
    step();
    f_ack = 1'b1;
    flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rsp_valid !== 1'b0 || i_cyc !== 1'b0 || cmd_ready !== 1'b1) flag = 1'b0;
    end
    f_ack = 1'b0;
    check("late_ack_ignored", 32'(flag), 32'd1);

    // Response backpressure with a pending command.
    tgt_mode = 0; tgt_wait = 0; rsp_ready = 1'b0;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h100; cmd_sel = 4'hF;
    step();
    for (int n = 0; n < 50 && !rsp_valid; n++) step();
    flag = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(rsp_valid === 1'b1 && rsp_dat === 32'hDEADBEEF && rsp_err === 1'b0 &&
            rsp_timeout === 1'b0 && cmd_ready === 1'b0 && i_cyc === 1'b0)) flag = 1'b0;
      step();
    end
    check("stall_rsp_stable", 32'(flag), 32'd1);
    rsp_ready = 1'b1;
    step();
    check("stall_release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("stall_release_no_cyc", 32'(i_cyc), 32'd0);
    check("stall_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stall_release_rsp_dat_cleared", rsp_dat, 32'h0);
    step();
    check("stall_pending_taken_cyc", 32'(i_cyc), 32'd1);
    check("stall_pending_taken_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && !rsp_valid; n++) step();
    check("stall_pending_rsp_dat", rsp_dat, 32'hDEADBEEF);
    step();

    // Asynchronous reset while the bus cycle is open.
    tgt_mode = 1;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h104; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_reset_in_bus", 32'(i_cyc), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_i_cyc", 32'(i_cyc), 32'd0);
    check("async_reset_i_stb", 32'(i_stb), 32'd0);
    check("async_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    tgt_mode = 0;
    flag = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rsp_valid !== 1'b0 || i_cyc !== 1'b0) flag = 1'b0;
    end
    check("post_reset_no_rsp", 32'(flag), 32'd1);
    do_cmd(1'b0, 32'h100, 32'h0, 4'hF, rd, re, rt, nc, st, dn);
    check("post_reset_read_done", 32'(dn), 32'd1);
    check("post_reset_read_dat", rd, 32'hDEADBEEF);
    check("post_reset_read_cyc", 32'(nc), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
